// File: rtl/multicycle_control_unit.sv
// Control FSM for a multicycle MIPS datapath: sequences PC/IR/MDR/register
// file enables, mux selects and ALU op, handshakes with memory via mem_ready
// and abandons memory accesses that stall for longer than WAIT_LIMIT cycles.
module multicycle_control_unit #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       branch_ne,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      I_EXEC    = 4'd10,
      I_WB      = 4'd11
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic               mem_state;
   logic               limit_hit;

   assign state = state_q;

   // State and wait counter registers; reset abandons any instruction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Memory-wait bookkeeping: a stall expires once the counter reaches the limit
   always_comb begin
      mem_state = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
      limit_hit = (WAIT_LIMIT > 0) && mem_state && !mem_ready &&
                  (wait_cnt_q == CNT_W'(WAIT_LIMIT));
   end

   // Next-state and output decode; all outputs default to 0 and are held 0 in reset
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      mem_timeout   = 1'b0;

      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = mem_ready;
            ir_write  = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW:    state_d = MEM_ADDR;
               OP_R:            state_d = R_EXEC;
               OP_BEQ, OP_BNE:  state_d = BRANCH;
               OP_J:            state_d = JUMP;
               OP_ADDI, OP_ORI: state_d = I_EXEC;
               default: begin
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
                  state_d    = FETCH;
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (opcode == OP_SW)      state_d = MEM_WRITE;
            else if (opcode == OP_LW) state_d = MEM_READ;
            else                      state_d = FETCH;
         end
         MEM_READ: begin
            mem_read  = 1'b1;
            i_or_d    = 1'b1;
            mdr_write = mem_ready;
            if (mem_ready) state_d = MEM_WB;
         end
         MEM_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         MEM_WRITE: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = FETCH;
         end
         R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = R_WB;
         end
         R_WB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_source     = 2'b01;
            pc_write_cond = 1'b1;
            branch_ne     = (opcode == OP_BNE);
            instr_done    = 1'b1;
            state_d       = FETCH;
         end
         JUMP: begin
            pc_source  = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = (opcode == OP_ORI) ? 2'b11 : 2'b00;
            state_d   = I_WB;
         end
         I_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         default: state_d = FETCH;
      endcase

      // An expired wait overrides the stay-in-state decision; strobes stay up
      // this last cycle, but completion enables are already 0 since ready is low
      if (limit_hit) begin
         mem_timeout = 1'b1;
         state_d     = FETCH;
      end

      // Count only while stalling in place; any transition restarts from 0
      if ((WAIT_LIMIT > 0) && mem_state && !mem_ready && !limit_hit)
         wait_cnt_d = wait_cnt_q + 1'b1;

      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         branch_ne     = 1'b0;
         i_or_d        = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         mdr_write     = 1'b0;
         reg_dst       = 1'b0;
         mem_to_reg    = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         pc_source     = 2'b00;
         instr_done    = 1'b0;
         illegal_op    = 1'b0;
         mem_timeout   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (WAIT_LIMIT=4): walks each
// instruction class, memory stalls, timeout, limit-cycle completion and reset.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
   logic       ir_write, mdr_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       instr_done, illegal_op, mem_timeout;
   logic [3:0] state;

   int n_cmp = 0;
   int n_err = 0;

   multicycle_control_unit #(.WAIT_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mdr_write(mdr_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .instr_done(instr_done), .illegal_op(illegal_op),
      .mem_timeout(mem_timeout), .state(state)
   );

   always #5 clk = ~clk;

   // en : pc_write pc_write_cond ir_write mdr_write mem_read mem_write reg_write instr_done illegal_op mem_timeout
   // sel: branch_ne i_or_d reg_dst mem_to_reg alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source[1:0]
   logic [9:0]  en;
   logic [10:0] sel;
   assign en  = {pc_write, pc_write_cond, ir_write, mdr_write, mem_read, mem_write,
                 reg_write, instr_done, illegal_op, mem_timeout};
   assign sel = {branch_ne, i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered at posedge+1: apply mem_ready, check, then advance one clock
   task automatic step(input string tag, input logic rdy, input logic [3:0] st,
                       input logic [9:0] e, input logic [10:0] s);
      mem_ready = rdy;
      #1;
      chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
      chk({tag, ".en"},    {22'd0, en},    {22'd0, e});
      chk({tag, ".sel"},   {21'd0, sel},   {21'd0, s});
      @(posedge clk);
      #1;
   endtask

   localparam logic [9:0]  EN_NONE  = 10'b0000000000;
   localparam logic [9:0]  EN_FETCH = 10'b1010100000;
   localparam logic [9:0]  EN_FSTL  = 10'b0000100000;
   localparam logic [9:0]  EN_WB    = 10'b0000001100;
   localparam logic [10:0] S_FETCH  = 11'b00000010000;
   localparam logic [10:0] S_DEC    = 11'b00000110000;
   localparam logic [10:0] S_MADDR  = 11'b00001100000;
   localparam logic [10:0] S_IORD   = 11'b01000000000;

   initial begin
      reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
      @(posedge clk); #1;
      chk("reset.state", {28'd0, state}, 32'd0);
      chk("reset.en",    {22'd0, en},    32'd0);
      chk("reset.sel",   {21'd0, sel},   32'd0);
      reset = 1'b0;

      // lw, no stalls: 0,1,2,3,4
      opcode = 6'b100011;
      step("lw.f",   1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("lw.d",   1'b1, 4'd1, EN_NONE,       S_DEC);
      step("lw.a",   1'b1, 4'd2, EN_NONE,       S_MADDR);
      step("lw.r",   1'b1, 4'd3, 10'b0001100000, S_IORD);
      step("lw.wb",  1'b1, 4'd4, EN_WB,         11'b00010000000);

      // R-type: 0,1,6,7
      opcode = 6'b000000;
      step("r.f",    1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("r.d",    1'b1, 4'd1, EN_NONE,       S_DEC);
      step("r.ex",   1'b1, 4'd6, EN_NONE,       11'b00001001000);
      step("r.wb",   1'b1, 4'd7, EN_WB,         11'b00100000000);

      // beq / bne: 0,1,8
      opcode = 6'b000100;
      step("beq.f",  1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("beq.d",  1'b1, 4'd1, EN_NONE,       S_DEC);
      step("beq.b",  1'b1, 4'd8, 10'b0100000100, 11'b00001000101);
      opcode = 6'b000101;
      step("bne.f",  1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("bne.d",  1'b1, 4'd1, EN_NONE,       S_DEC);
      step("bne.b",  1'b1, 4'd8, 10'b0100000100, 11'b10001000101);

      // j: 0,1,9
      opcode = 6'b000010;
      step("j.f",    1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("j.d",    1'b1, 4'd1, EN_NONE,       S_DEC);
      step("j.j",    1'b1, 4'd9, 10'b1000000100, 11'b00000000010);

      // addi / ori: 0,1,10,11
      opcode = 6'b001000;
      step("addi.f", 1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("addi.d", 1'b1, 4'd1, EN_NONE,       S_DEC);
      step("addi.x", 1'b1, 4'd10, EN_NONE,      S_MADDR);
      step("addi.w", 1'b1, 4'd11, EN_WB,        11'b00000000000);
      opcode = 6'b001101;
      step("ori.f",  1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("ori.d",  1'b1, 4'd1, EN_NONE,       S_DEC);
      step("ori.x",  1'b1, 4'd10, EN_NONE,      11'b00001101100);
      step("ori.w",  1'b1, 4'd11, EN_WB,        11'b00000000000);

      // sw, no stalls: 0,1,2,5
      opcode = 6'b101011;
      step("sw.f",   1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("sw.d",   1'b1, 4'd1, EN_NONE,       S_DEC);
      step("sw.a",   1'b1, 4'd2, EN_NONE,       S_MADDR);
      step("sw.w",   1'b1, 4'd5, 10'b0000010100, S_IORD);

      // FETCH stalled 3 cycles, then ready on the 4th
      opcode = 6'b000010;
      step("fst.0",  1'b0, 4'd0, EN_FSTL,       S_FETCH);
      step("fst.1",  1'b0, 4'd0, EN_FSTL,       S_FETCH);
      step("fst.2",  1'b0, 4'd0, EN_FSTL,       S_FETCH);
      step("fst.3",  1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("fst.d",  1'b1, 4'd1, EN_NONE,       S_DEC);
      step("fst.j",  1'b1, 4'd9, 10'b1000000100, 11'b00000000010);

      // sw with memory stuck: 5 cycles in MEM_WRITE, timeout on the 5th
      opcode = 6'b101011;
      step("swt.f",  1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("swt.d",  1'b1, 4'd1, EN_NONE,       S_DEC);
      step("swt.a",  1'b1, 4'd2, EN_NONE,       S_MADDR);
      for (int i = 0; i < 4; i++)
         step("swt.wait", 1'b0, 4'd5, 10'b0000010000, S_IORD);
      step("swt.to", 1'b0, 4'd5, 10'b0000010001, S_IORD);
      step("swt.f2", 1'b1, 4'd0, EN_FETCH,      S_FETCH);

      // lw with ready arriving exactly on the limit cycle: completes normally
      opcode = 6'b100011;
      step("lwl.d",  1'b1, 4'd1, EN_NONE,       S_DEC);
      step("lwl.a",  1'b1, 4'd2, EN_NONE,       S_MADDR);
      for (int i = 0; i < 4; i++)
         step("lwl.wait", 1'b0, 4'd3, 10'b0000100000, S_IORD);
      step("lwl.r",  1'b1, 4'd3, 10'b0001100000, S_IORD);
      step("lwl.wb", 1'b1, 4'd4, EN_WB,         11'b00010000000);

      // Unsupported opcode: flagged in DECODE, back to FETCH
      opcode = 6'b111111;
      step("ill.f",  1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("ill.d",  1'b1, 4'd1, 10'b0000000110, S_DEC);
      step("ill.f2", 1'b1, 4'd0, EN_FETCH,      S_FETCH);

      // Asynchronous reset in the middle of a stalled MEM_WRITE
      opcode = 6'b101011;
      step("rst.d",  1'b1, 4'd1, EN_NONE,       S_DEC);
      step("rst.a",  1'b1, 4'd2, EN_NONE,       S_MADDR);
      mem_ready = 1'b0;
      #1;
      chk("rst.pre.mem_write", {31'd0, mem_write}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rst.mid.mem_write", {31'd0, mem_write}, 32'd0);
      chk("rst.mid.state",     {28'd0, state},     32'd0);
      chk("rst.mid.en",        {22'd0, en},        32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      step("rst.f",  1'b1, 4'd0, EN_FETCH,      S_FETCH);
      step("rst.d2", 1'b1, 4'd1, EN_NONE,       S_DEC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
